tetris_besleyici: RTL and testbench
===================================

# tetris_besleyici

Stimulus source for the `tetris` height accumulator: generates a 16-piece stream of 3-bit pieces from a seeded 16-bit LFSR and presents them one per accepted cycle under a valid/ready handshake. In parallel it tallies per-column occupancy and reports the expected final stack height, so a bench or on-chip self-test can compare it against the accumulator's result. It is the producer end of the `parca` interface.

## Interface

Parameters:
- `ADET`, 16, pieces per run (5-bit counters; must be 1..16)
- `VARSAYILAN_TOHUM`, 16'hACE1, seed substituted when `tohum` is zero

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `baslat`  input  1  start pulse; sampled only in BOS or BITTI
- `tohum`  input  16  LFSR seed, captured on accepted `baslat`
- `hazir`  input  1  consumer ready; transfer when `gecerli && hazir`
- `parca`  output  3  current piece; bit k = column k occupied
- `gecerli`  output  1  `parca` valid
- `cevrim`  output  5  transfers completed in this run
- `bitti`  output  1  run complete, `beklenen` valid
- `beklenen`  output  5  expected max column height

## Operation

- States: BOS (idle), GONDER (streaming), MAKS (one-cycle max compute), BITTI (result hold).
- BOS: `baslat`=1 → GONDER; load `lfsr <= (tohum==0) ? VARSAYILAN_TOHUM : tohum`; clear `cevrim`, column counters y0/y1/y2, `beklenen`.
- GONDER: `gecerli`=1, `parca = lfsr[2:0]`. On transfer: y_k += parca[k] (5-bit, no overflow possible for ADET≤16); `cevrim` += 1; LFSR steps. On the transfer that makes `cevrim`==ADET → MAKS. `hazir`=0: all state, `parca`, `cevrim` held.
- LFSR step: `fb = l[15]^l[13]^l[12]^l[10]`; `l <= {l[14:0], fb}`. Nonzero seed never reaches zero.
- MAKS: `beklenen <=` max(y0, y1, y2) (ties irrelevant) → BITTI.
- BITTI: `bitti`=1, `beklenen` and `cevrim` held; `baslat`=1 restarts exactly as from BOS (new seed, counters cleared, `bitti` drops next cycle).
- `baslat` in GONDER or MAKS: ignored.
- `parca` outside GONDER: 3'b000.

## Timing

- Reset (`rst_n`=0 at an edge): state BOS, `gecerli`=0, `parca`=0, `cevrim`=0, `bitti`=0, `beklenen`=0, lfsr=0, y0..y2=0. Takes priority over every other input, including mid-run; no partial result survives.
- `baslat` sampled at edge N → `gecerli`=1 and first piece visible after edge N, i.e. during cycle N+1.
- With `hazir` held 1: transfers at edges N+1..N+16; `gecerli` falls after edge N+16; MAKS during N+17; `bitti`=1 and `beklenen` valid from cycle N+18.
- Each cycle with `hazir`=0 in GONDER adds exactly one cycle to the above.
- `cevrim` increments after each transfer edge; reads 16 in MAKS/BITTI.
- Restart from BITTI at edge M: `gecerli`=1 in cycle M+1, `bitti`=0, `cevrim`=0.

## Test plan

- Reset then idle: `rst_n`=0 one edge, release, no `baslat` for 20 cycles → all outputs 0, `gecerli` never asserts.
- Seed 16'hFFFF, `hazir`=1: piece stream 111,110,100, nine × 000, 001,011,110,101 → `cevrim`=16, y0=4, y1=4, y2=5, `beklenen`=5, `bitti` at cycle N+18.
- Seed 0 → first piece 3'b001 (from 16'hACE1), LFSR state after first transfer 16'h59C3.
- Backpressure: seed 16'hFFFF, `hazir`=0 for cycles 3–5 of GONDER → `parca` stable at 3'b000 while stalled, `cevrim` frozen at 3, same final `beklenen`=5, `bitti` three cycles later.
- Reset mid-run: `rst_n`=0 after 7 transfers → next cycle BOS, `gecerli`=0, `cevrim`=0, `beklenen`=0; new `baslat` runs full 16.
- Restart/ignore: `baslat` pulses during GONDER have no effect; `baslat` in BITTI with seed 16'hFFFF repeats identical stream and `beklenen`=5.

Source files
------------

// File: rtl/tetris_besleyici.sv
// Seeded LFSR piece source for the tetris height accumulator.
// Streams ADET 3-bit pieces under valid/ready and reports the expected final stack height.
module tetris_besleyici #(
  parameter int          ADET             = 16,
  parameter logic [15:0] VARSAYILAN_TOHUM = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baslat,
  input  logic [15:0] tohum,
  input  logic        hazir,
  output logic [2:0]  parca,
  output logic        gecerli,
  output logic [4:0]  cevrim,
  output logic        bitti,
  output logic [4:0]  beklenen
);

  typedef enum logic [1:0] {BOS, GONDER, MAKS, BITTI} durum_t;

  localparam logic [4:0] SON = 5'(ADET);

  durum_t      durum, durum_sonraki;
  logic [15:0] lfsr;
  logic [15:0] lfsr_ileri;
  logic        geri_besleme;
  logic [4:0]  y0, y1, y2;
  logic [4:0]  cevrim_r, beklenen_r;
  logic [4:0]  maks01, maks_hepsi;
  logic        aktarim;
  logic        baslat_kabul;
  logic        son_aktarim;

  assign aktarim      = (durum == GONDER) && hazir;
  assign baslat_kabul = baslat && ((durum == BOS) || (durum == BITTI));
  assign son_aktarim  = aktarim && (cevrim_r == (SON - 5'd1));

  assign geri_besleme = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_ileri   = {lfsr[14:0], geri_besleme};

  // Tie-breaking does not matter; only the tallest column is reported.
  assign maks01     = (y0 > y1) ? y0 : y1;
  assign maks_hepsi = (maks01 > y2) ? maks01 : y2;

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOS:     if (baslat) durum_sonraki = GONDER;
      GONDER:  if (son_aktarim) durum_sonraki = MAKS;
      MAKS:    durum_sonraki = BITTI;
      BITTI:   if (baslat) durum_sonraki = GONDER;
      default: durum_sonraki = BOS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum      <= BOS;
      lfsr       <= 16'h0000;
      y0         <= 5'd0;
      y1         <= 5'd0;
      y2         <= 5'd0;
      cevrim_r   <= 5'd0;
      beklenen_r <= 5'd0;
    end else begin
      durum <= durum_sonraki;
      if (baslat_kabul) begin
        lfsr       <= (tohum == 16'h0000) ? VARSAYILAN_TOHUM : tohum;
        y0         <= 5'd0;
        y1         <= 5'd0;
        y2         <= 5'd0;
        cevrim_r   <= 5'd0;
        beklenen_r <= 5'd0;
      end else if (aktarim) begin
        lfsr     <= lfsr_ileri;
        y0       <= y0 + {4'd0, lfsr[0]};
        y1       <= y1 + {4'd0, lfsr[1]};
        y2       <= y2 + {4'd0, lfsr[2]};
        cevrim_r <= cevrim_r + 5'd1;
      end else if (durum == MAKS) begin
        beklenen_r <= maks_hepsi;
      end
    end
  end

  assign gecerli  = (durum == GONDER);
  assign parca    = gecerli ? lfsr[2:0] : 3'b000;
  assign bitti    = (durum == BITTI);
  assign cevrim   = cevrim_r;
  assign beklenen = beklenen_r;

endmodule

// File: tb/tb_tetris_besleyici.sv
// Directed bench for tetris_besleyici: hand-computed piece streams, stalls, resets and restarts.
module tb_tetris_besleyici;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        baslat;
  logic [15:0] tohum;
  logic        hazir;
  logic [2:0]  parca;
  logic        gecerli;
  logic [4:0]  cevrim;
  logic        bitti;
  logic [4:0]  beklenen;

  int vektor_sayisi = 0;
  int hata_sayisi   = 0;

  // Stream for seed 16'hFFFF, worked out by hand from the feedback taps 15,13,12,10.
  logic [2:0] ffff_akisi [16] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000,
                                  3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                  3'b001, 3'b011, 3'b110, 3'b101};

  tetris_besleyici #(.ADET(16), .VARSAYILAN_TOHUM(16'hACE1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baslat   (baslat),
    .tohum    (tohum),
    .hazir    (hazir),
    .parca    (parca),
    .gecerli  (gecerli),
    .cevrim   (cevrim),
    .bitti    (bitti),
    .beklenen (beklenen)
  );

  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] istenen);
    vektor_sayisi++;
    if (gozlenen !== istenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %0h, expected %0h", etiket, gozlenen, istenen);
    end
  endtask

  // Full run with seed 16'hFFFF; optional stall after 'dur_at' transfers and an ignored baslat pulse.
  task automatic kos(input int dur_at, input int dur_n, input bit yoksay_darbe);
    tohum  = 16'hFFFF;
    baslat = 1'b1;
    hazir  = 1'b1;
    @(negedge clk);
    baslat = 1'b0;
    kontrol("start_bitti_low", 32'(bitti), 32'd0);
    for (int i = 0; i < 16; i++) begin
      kontrol($sformatf("gecerli_%0d", i), 32'(gecerli), 32'd1);
      kontrol($sformatf("parca_%0d", i), 32'(parca), 32'(ffff_akisi[i]));
      kontrol($sformatf("cevrim_%0d", i), 32'(cevrim), 32'(i));
      if (i == dur_at) begin
        hazir = 1'b0;
        for (int k = 0; k < dur_n; k++) begin
          @(negedge clk);
          kontrol($sformatf("stall_parca_%0d", k), 32'(parca), 32'(ffff_akisi[i]));
          kontrol($sformatf("stall_cevrim_%0d", k), 32'(cevrim), 32'(i));
          kontrol($sformatf("stall_gecerli_%0d", k), 32'(gecerli), 32'd1);
        end
        hazir = 1'b1;
      end
      if (yoksay_darbe && i == 5) begin
        baslat = 1'b1;
        tohum  = 16'h1234;
      end
      @(negedge clk);
      baslat = 1'b0;
      tohum  = 16'hFFFF;
    end
    // MAKS cycle
    kontrol("maks_gecerli", 32'(gecerli), 32'd0);
    kontrol("maks_parca", 32'(parca), 32'd0);
    kontrol("maks_bitti", 32'(bitti), 32'd0);
    kontrol("maks_cevrim", 32'(cevrim), 32'd16);
    @(negedge clk);
    kontrol("bitti_set", 32'(bitti), 32'd1);
    kontrol("beklenen", 32'(beklenen), 32'd5);
    kontrol("bitti_cevrim", 32'(cevrim), 32'd16);
    kontrol("y0", 32'(dut.y0), 32'd4);
    kontrol("y1", 32'(dut.y1), 32'd4);
    kontrol("y2", 32'(dut.y2), 32'd5);
    @(negedge clk);
    kontrol("bitti_hold", 32'(bitti), 32'd1);
    kontrol("beklenen_hold", 32'(beklenen), 32'd5);
  endtask

  initial begin
    bit gecerli_goruldu;
    rst_n  = 1'b0;
    baslat = 1'b0;
    tohum  = 16'h0000;
    hazir  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    kontrol("rst_gecerli", 32'(gecerli), 32'd0);
    kontrol("rst_parca", 32'(parca), 32'd0);
    kontrol("rst_cevrim", 32'(cevrim), 32'd0);
    kontrol("rst_bitti", 32'(bitti), 32'd0);
    kontrol("rst_beklenen", 32'(beklenen), 32'd0);
    kontrol("rst_lfsr", 32'(dut.lfsr), 32'd0);

    gecerli_goruldu = 1'b0;
    hazir = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gecerli) gecerli_goruldu = 1'b1;
    end
    kontrol("idle_gecerli_never", 32'(gecerli_goruldu), 32'd0);
    kontrol("idle_cevrim", 32'(cevrim), 32'd0);
    kontrol("idle_bitti", 32'(bitti), 32'd0);

    // Plain run with an ignored baslat pulse mid-stream.
    kos(-1, 0, 1'b1);
    // Restart straight from BITTI with three stall cycles after three transfers.
    kos(3, 3, 1'b0);

    // Seed 0 falls back to 16'hACE1; then reset mid-run after 7 transfers.
    tohum  = 16'h0000;
    baslat = 1'b1;
    hazir  = 1'b0;
    @(negedge clk);
    baslat = 1'b0;
    kontrol("seed0_parca", 32'(parca), 32'd1);
    kontrol("seed0_lfsr", 32'(dut.lfsr), 32'h0000ACE1);
    kontrol("seed0_bitti", 32'(bitti), 32'd0);
    hazir = 1'b1;
    @(negedge clk);
    kontrol("seed0_lfsr_step", 32'(dut.lfsr), 32'h000059C3);
    kontrol("seed0_parca2", 32'(parca), 32'd3);
    kontrol("seed0_cevrim1", 32'(cevrim), 32'd1);
    repeat (6) @(negedge clk);
    kontrol("mid_cevrim7", 32'(cevrim), 32'd7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    kontrol("midrst_gecerli", 32'(gecerli), 32'd0);
    kontrol("midrst_cevrim", 32'(cevrim), 32'd0);
    kontrol("midrst_beklenen", 32'(beklenen), 32'd0);
    kontrol("midrst_bitti", 32'(bitti), 32'd0);
    kontrol("midrst_parca", 32'(parca), 32'd0);
    @(negedge clk);
    kontrol("midrst_still_idle", 32'(gecerli), 32'd0);

    // Fresh full run from BOS after the reset.
    kos(-1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
    $finish;
  end

endmodule
